// File: rtl/cla_iterative_addsub_ctrl_pkg.sv
// cla_pkg: shared slice width and sequencer state encoding
package cla_pkg;
  localparam int SLICE_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} addsub_state_t;
endpackage

// File: rtl/cla_iterative_addsub_ctrl_slice.sv
// cla_slice_4: combinational 4-bit generate/propagate carry-lookahead adder slice
module cla_slice_4
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] A,
  input  logic [SLICE_W-1:0] B,
  input  logic               c_in,
  output logic [SLICE_W-1:0] S,
  output logic               c_out
);
  logic [SLICE_W-1:0] g, p, c;
  always_comb begin
    g = A & B;
    p = A ^ B;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);
    c_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c_in);
    S = p ^ c;
  end
endmodule

// File: rtl/cla_iterative_addsub_ctrl.sv
// cla_iterative_addsub_ctrl: nibble-serial add/subtract through one shared CLA slice, valid/ready on both sides
module cla_iterative_addsub_ctrl
  import cla_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int NN = WIDTH / SLICE_W;
  localparam int CW = (NN > 1) ? $clog2(NN) : 1;
  if ((WIDTH % SLICE_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and >= 8");
  end
  addsub_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, sum_q, sum_d, sum_nx;
  logic carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic [SLICE_W-1:0] s;
  logic c_out, last;
  cla_slice_4 u_slice (
    .A    (opa_q[SLICE_W-1:0]),
    .B    (opb_q[SLICE_W-1:0]),
    .c_in (carry_q),
    .S    (s),
    .c_out(c_out)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    last = cnt_q == CW'(NN - 1);
    state_d = state_q == IDLE ? (in_valid ? RUN : IDLE)
            : state_q == RUN  ? (last ? DONE : RUN)
            : (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state_q == IDLE;
    out_valid = state_q == DONE;
    sum = sum_q;
    cout = cout_q;
    ovf = ovf_q;
    zero = zero_q;
  end
  always_comb begin
    sum_nx = {s, sum_q[WIDTH-1:SLICE_W]};
    opa_d = opa_q;
    opb_d = opb_q;
    sum_d = sum_q;
    carry_d = carry_q;
    cnt_d = cnt_q;
    cout_d = cout_q;
    ovf_d = ovf_q;
    zero_d = zero_q;
    if (state_q == IDLE && in_valid) begin
      opa_d = a;
      opb_d = sub ? ~b : b;
      carry_d = sub;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      opa_d = opa_q >> SLICE_W;
      opb_d = opb_q >> SLICE_W;
      sum_d = sum_nx;
      carry_d = c_out;
      cnt_d = last ? cnt_q : cnt_q + CW'(1);
      if (last) begin
        cout_d = c_out;
        ovf_d = (opa_q[SLICE_W-1] ~^ opb_q[SLICE_W-1]) & (s[SLICE_W-1] ^ opa_q[SLICE_W-1]);
        zero_d = sum_nx == '0;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
      cnt_q <= '0;
      cout_q <= 1'b0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      opa_q <= opa_d;
      opb_q <= opb_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
      cnt_q <= cnt_d;
      cout_q <= cout_d;
      ovf_q <= ovf_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_cla_iterative_addsub_ctrl.sv
// tb_cla_iterative_addsub_ctrl: directed and random checks of the nibble-serial add/sub against an arithmetic model
module tb_cla_iterative_addsub_ctrl;
  localparam int W = 32;
  localparam int NN = W / 4;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, sub;
  logic [W-1:0] a, b;
  logic in_ready, out_valid, cout, ovf, zero;
  logic [W-1:0] sum;
  int checks = 0;
  int failures = 0;
  bit busy = 1'b0;
  int age = 0;
  int n_acc = 0;
  logic [W:0] r;
  logic [W-1:0] e_sum, h_sum = '0;
  logic e_cout, e_ovf, e_zero;
  logic h_cout = 1'b0, h_ovf = 1'b0, h_zero = 1'b0;
  cla_iterative_addsub_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      busy = 1'b0;
      age = 0;
      h_sum = '0;
      h_cout = 1'b0;
      h_ovf = 1'b0;
      h_zero = 1'b0;
    end else if (busy) begin
      if (age >= NN && out_ready) begin
        busy = 1'b0;
        h_sum = e_sum;
        h_cout = e_cout;
        h_ovf = e_ovf;
        h_zero = e_zero;
      end else if (age < NN) age++;
    end else if (in_valid) begin
      busy = 1'b1;
      age = 0;
      n_acc++;
      r = sub ? {(a >= b) ? 1'b1 : 1'b0, a - b} : {1'b0, a} + {1'b0, b};
      e_cout = r[W];
      e_sum = r[W-1:0];
      e_zero = e_sum == 0;
      e_ovf = sub ? (a[W-1] != b[W-1] && e_sum[W-1] != a[W-1])
                  : (a[W-1] == b[W-1] && e_sum[W-1] != a[W-1]);
    end
  end
  always @(negedge clk) begin
    chk("in_ready", 64'(in_ready), 64'(!busy));
    chk("out_valid", 64'(out_valid), 64'(busy && age >= NN));
    if (busy && age >= NN) begin
      chk("sum", 64'(sum), 64'(e_sum));
      chk("cout", 64'(cout), 64'(e_cout));
      chk("ovf", 64'(ovf), 64'(e_ovf));
      chk("zero", 64'(zero), 64'(e_zero));
    end else if (!busy) begin
      chk("idle_sum", 64'(sum), 64'(h_sum));
      chk("idle_flags", 64'({cout, ovf, zero}), 64'({h_cout, h_ovf, h_zero}));
    end
  end
  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic ts, input logic [W-1:0] xs, input logic xc, input logic xo,
                       input logic xz, input bit stall);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(NN));
    chk({nm, "_sum"}, 64'(sum), 64'(xs));
    chk({nm, "_flags"}, 64'({cout, ovf, zero}), 64'({xc, xo, xz}));
    if (stall) begin
      repeat (5) begin
        in_valid = 1'b1; a = $urandom; b = $urandom;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk({nm, "_stall_sum"}, 64'(sum), 64'(xs));
      chk({nm, "_stall_hs"}, 64'({out_valid, in_ready}), 64'(2'b10));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({nm, "_released"}, 64'({out_valid, in_ready}), 64'(2'b01));
  endtask
  initial begin
    int cyc, start;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 64'({sum, cout, ovf, zero}), 64'(0));
    chk("reset_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    rst = 1'b0;
    do_op("t1_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op("t2_subovf", 32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    do_op("t3_addovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op("t3_subneg", 32'h5, 32'h7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op("t4_stall", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t5_abort_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    chk("t5_abort_sum", 64'({sum, cout, ovf, zero}), 64'(0));
    @(negedge clk); #1;
    rst = 1'b0;
    do_op("t5_fresh", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, 1'b0);
    start = n_acc;
    cyc = 0;
    while (cyc < 60000 && n_acc - start < 2000) begin
      @(posedge clk); #1;
      in_valid = $urandom_range(0, 3) != 0;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      sub = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      cyc++;
    end
    chk("t6_ops_done", 64'(n_acc - start >= 2000), 64'(1));
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
